// File: rtl/div_unit_seq_pkg.sv
// Shared types and constants for the iterative restoring divider.
// The optional DIV_ZERO_FLAG_EN build is handled in the interface and top.
package div_pkg;
  localparam int DIV_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  // Wide enough to hold the iteration count WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/div_unit_seq_if.sv
// Start/operand/result bundle between a requester and div_unit_seq.
// DIV_ZERO_FLAG_EN adds the div_by_zero result flag.
interface div_unit_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] div_rd;
  logic [WIDTH-1:0] rem_rd;
`ifdef DIV_ZERO_FLAG_EN
  logic             div_by_zero;

  modport master (output start, dividend, divisor,
                  input  busy, done, div_rd, rem_rd, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, div_rd, rem_rd, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, div_rd, rem_rd);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, div_rd, rem_rd);
`endif
endinterface

// File: rtl/div_unit_seq_step.sv
// One combinational restoring-division step: shift {rem,quo} left, trial-subtract
// the divisor, keep the difference only when it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic        [WIDTH:0]   shifted;
  logic signed [WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = $signed({1'b0, shifted}) - $signed({2'b00, divisor});
    // A restored remainder is below the divisor, so it always fits in WIDTH bits.
    if (trial >= 0) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_unit_seq.sv
// Iterative WIDTH-bit unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_FLAG_EN: zero divisor completes in one clock and raises div_by_zero.
module div_unit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic          clk,
  input  logic          rst,
  div_unit_seq_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] div_rd_q, rem_rd_q;
  logic             accept, last_step, zero_div;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  assign accept    = bus.start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == CNT_W'(1));
`ifdef DIV_ZERO_FLAG_EN
  assign zero_div  = (bus.divisor == '0);
`else
  assign zero_div  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = zero_div ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      RUN:     if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results move into div_rd/rem_rd only at completion and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      div_rd_q <= '0;
      rem_rd_q <= '0;
    end else if (accept) begin
      rem_q <= '0;
      quo_q <= bus.dividend;
      dvs_q <= bus.divisor;
      if (zero_div) begin
        cnt      <= '0;
        div_rd_q <= '1;
        rem_rd_q <= bus.dividend;
      end else begin
        cnt      <= CNT_W'(WIDTH);
      end
    end else if (state == RUN) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt   <= cnt - 1'b1;
      if (last_step) begin
        div_rd_q <= quo_nxt;
        rem_rd_q <= rem_nxt;
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      dz_q <= 1'b0;
    else if (accept && zero_div)  dz_q <= 1'b1;
    else if (last_step)           dz_q <= 1'b0;
  end

  assign bus.div_by_zero = dz_q;
`endif

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.div_rd = div_rd_q;
  assign bus.rem_rd = rem_rd_q;
endmodule
